pid_servo_ctrl: RTL and testbench
=================================

# pid_servo_ctrl

Parametrised, time-sampled PID position controller for the servo path. Once per sample period it captures a desired position and a measured position. It computes P, I and D terms in a short multi-cycle pipeline, applies anti-windup and output saturation, and presents a clamped duty word with a one-cycle valid strobe to the PWM generator. It replaces the single-cycle, free-running controller with a fixed sample rate, configurable widths and gains, and status outputs.

## Interface
- POS_W, 12: width of setpoint/feedback (unsigned)
- DUTY_W, 18: width of duty_out (unsigned)
- KP, 100 / KI, 1 / KD, 10: signed integer gains
- GAIN_SHIFT, 0: arithmetic right shift applied to the summed P+I+D term (fixed-point gain scaling)
- OFFSET, 75000: duty for zero correction (90°)
- MIN_DUTY, 50000 / MAX_DUTY, 100000: output clamp (0° / 180°); MIN_DUTY ≤ OFFSET ≤ MAX_DUTY < 2^DUTY_W
- INT_LIM, 4096: integral clamp, integral ∈ [−INT_LIM, +INT_LIM]
- SAMPLE_DIV, 50000: clocks per sample; must be ≥ 4
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  enables sampling
- setpoint  in  POS_W  desired position
- feedback  in  POS_W  measured position
- duty_out  out  DUTY_W  registered duty word to PWM
- duty_valid  out  1  one-cycle pulse when duty_out updates
- busy  out  1  high while a computation is in flight
- sat_hi / sat_lo  out  1  last update clamped at MAX_DUTY / MIN_DUTY

## Operation
- Reset values: duty_out=OFFSET, duty_valid=0, busy=0, sat_hi=0, sat_lo=0. Internal: integral=0, last_err=0, sample counter=0, state IDLE.
- Sample counter:
  - While en=1 it counts 0..SAMPLE_DIV−1 and wraps to 0.
  - tick = en && count==SAMPLE_DIV−1.
  - While en=0 it is held at 0 and no tick is generated. An in-flight computation still completes.
  - integral and last_err are retained across en toggles.
- FSM states: IDLE, ERR, SUM, SAT. busy = (state != IDLE).
  - IDLE: on tick, register sp_r←setpoint and fb_r←feedback, then go to ERR.
  - ERR: compute error e = sp_r − fb_r, signed POS_W+1 bits.
    - err_r←e
    - deriv_r←e − last_err
    - last_err←e
    - Integral update:
      - Hold (no add) if sat_hi=1 and e>0, or if sat_lo=1 and e<0. This is conditional anti-windup.
      - Otherwise integral←clamp(integral+e, ±INT_LIM).
    - Go to SUM.
  - SUM: acc←OFFSET + ((KP·err_r + KI·integral + KD·deriv_r) >>> GAIN_SHIFT). Go to SAT.
  - SAT:
    - If acc>MAX_DUTY: duty_out←MAX_DUTY, sat_hi←1, sat_lo←0.
    - Else if acc<MIN_DUTY: duty_out←MIN_DUTY, sat_lo←1, sat_hi←0.
    - Else: duty_out←acc[DUTY_W−1:0], both flags←0.
    - In all cases duty_valid←1. Go to IDLE.
- Arithmetic rules:
  - All internal math is signed, using a 40-bit accumulator. Products and sums must never overflow for the default parameters.
  - The shift is arithmetic, i.e. it rounds toward −∞.
  - The integral register is signed, wide enough for ±INT_LIM.
- First sample after reset: last_err=0, so deriv = e (derivative kick is accepted).
- The integral clamp is applied after each add. Reaching exactly ±INT_LIM is legal.
- Reset asserted in any state aborts the computation:
  - All outputs and internal state return to reset values on that edge.
  - No duty_valid is produced for the aborted sample.

## Timing
- Tick in cycle T: inputs captured at the end of T.
- busy is high in cycles T+1..T+3.
- duty_out and status flags change at the edge ending T+3 and are visible from T+4.
- duty_valid is high exactly in cycle T+4 and low otherwise.
- Latency from sample capture to visible duty_out: 4 clocks.
- SAMPLE_DIV ≥ 4 guarantees the FSM is in IDLE at every tick, so no overrun handling is needed.
- First tick arrives SAMPLE_DIV cycles after en rises from 0 (counter starting at 0).
- duty_out holds its value between updates; it is never combinational from the inputs.

## Test plan
Default gains, GAIN_SHIFT=0, SAMPLE_DIV=4 for all scenarios.
- Reset: assert rst for 2 cycles → duty_out=75000; duty_valid, busy, sat_hi, sat_lo all 0; no duty_valid pulse while en=0.
- Zero error: setpoint=feedback=2048, en=1 → duty_valid in the 4th cycle after each tick; duty_out=75000; flags 0.
- Step response: setpoint=100, feedback=0.
  - Sample 1 → duty_out=86100 (75000+10000+100+1000).
  - Sample 2 → duty_out=85200 (integral=200, deriv=0).
- High saturation: setpoint=4095, feedback=0.
  - Sample 1 → duty_out=100000, sat_hi=1, integral=4095.
  - Sample 2 → integral held at 4095 (anti-windup).
- Low saturation and integral clamp:
  - setpoint=0, feedback=4095 → duty_out=50000, sat_lo=1.
  - With INT_LIM=150, setpoint=100, feedback=0 → integral 100 then 150 (clamped); sample 2 duty_out=85150.
- Mid-operation reset: assert rst in cycle T+2 of a sample → next cycle duty_out=75000, no duty_valid; next sample behaves as the first after reset (deriv=e).

Source files
------------

// File: rtl/pid_servo_ctrl.sv
// Time-sampled PID position controller producing a clamped servo duty word.
// Latency: inputs captured on the sample tick, duty_out/flags visible 4 clocks later with duty_valid.
// Backpressure: none; the PWM sink must accept every duty_valid pulse (one per SAMPLE_DIV clocks).
module pid_servo_ctrl #(
    parameter int POS_W      = 12,
    parameter int DUTY_W     = 18,
    parameter int KP         = 100,
    parameter int KI         = 1,
    parameter int KD         = 10,
    parameter int GAIN_SHIFT = 0,
    parameter int OFFSET     = 75000,
    parameter int MIN_DUTY   = 50000,
    parameter int MAX_DUTY   = 100000,
    parameter int INT_LIM    = 4096,
    parameter int SAMPLE_DIV = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [POS_W-1:0]  setpoint,
    input  logic [POS_W-1:0]  feedback,
    output logic [DUTY_W-1:0] duty_out,
    output logic              duty_valid,
    output logic              busy,
    output logic              sat_hi,
    output logic              sat_lo
);

    localparam int ACC_W = 40;
    localparam int ERR_W = POS_W + 1;
    localparam int DER_W = POS_W + 2;
    localparam int INT_W = $clog2(INT_LIM + 1) + 1;
    localparam int CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ERR  = 2'd1;
    localparam logic [1:0] S_SUM  = 2'd2;
    localparam logic [1:0] S_SAT  = 2'd3;

    localparam logic signed [ACC_W-1:0] KP_A     = ACC_W'(KP);
    localparam logic signed [ACC_W-1:0] KI_A     = ACC_W'(KI);
    localparam logic signed [ACC_W-1:0] KD_A     = ACC_W'(KD);
    localparam logic signed [ACC_W-1:0] OFFSET_A = ACC_W'(OFFSET);
    localparam logic signed [ACC_W-1:0] MAX_A    = ACC_W'(MAX_DUTY);
    localparam logic signed [ACC_W-1:0] MIN_A    = ACC_W'(MIN_DUTY);
    localparam logic signed [ACC_W-1:0] INT_HI_A = ACC_W'(INT_LIM);
    localparam logic signed [ACC_W-1:0] INT_LO_A = ACC_W'(-INT_LIM);

    logic [1:0]               r_state;
    logic [CNT_W-1:0]         r_cnt;
    logic [POS_W-1:0]         r_sp;
    logic [POS_W-1:0]         r_fb;
    logic signed [ERR_W-1:0]  r_err;
    logic signed [ERR_W-1:0]  r_last_err;
    logic signed [DER_W-1:0]  r_deriv;
    logic signed [INT_W-1:0]  r_integ;
    logic signed [ACC_W-1:0]  r_acc;

    logic                     w_tick;
    logic signed [ERR_W-1:0]  w_err;
    logic signed [DER_W-1:0]  w_deriv;
    logic                     w_err_pos;
    logic                     w_err_neg;
    logic                     w_hold;
    logic signed [ACC_W-1:0]  w_int_sum;
    logic signed [ACC_W-1:0]  w_pid;
    logic signed [ACC_W-1:0]  w_acc;

    assign w_tick    = en && (r_cnt == CNT_LAST);
    assign busy      = (r_state != S_IDLE);

    // Zero-extend the unsigned positions by one bit so the difference is exact.
    assign w_err     = $signed({1'b0, r_sp}) - $signed({1'b0, r_fb});
    assign w_deriv   = DER_W'(w_err) - DER_W'(r_last_err);
    assign w_err_neg = w_err[ERR_W-1];
    assign w_err_pos = !w_err[ERR_W-1] && (w_err != '0);

    // Conditional anti-windup: stop integrating further into the rail we are already pinned on.
    assign w_hold    = (sat_hi && w_err_pos) || (sat_lo && w_err_neg);
    assign w_int_sum = ACC_W'(r_integ) + ACC_W'(w_err);

    assign w_pid = KP_A * ACC_W'(r_err) + KI_A * ACC_W'(r_integ) + KD_A * ACC_W'(r_deriv);
    assign w_acc = OFFSET_A + (w_pid >>> GAIN_SHIFT);

    // Sample counter: free-runs while enabled, parked at zero otherwise.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Controller FSM and datapath: capture, error/integral, weighted sum, then clamp.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_sp       <= '0;
            r_fb       <= '0;
            r_err      <= '0;
            r_last_err <= '0;
            r_deriv    <= '0;
            r_integ    <= '0;
            r_acc      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_tick) begin
                        r_sp    <= setpoint;
                        r_fb    <= feedback;
                        r_state <= S_ERR;
                    end
                end
                S_ERR: begin
                    r_err      <= w_err;
                    r_deriv    <= w_deriv;
                    r_last_err <= w_err;
                    if (!w_hold) begin
                        if (w_int_sum > INT_HI_A) begin
                            r_integ <= INT_W'(INT_HI_A);
                        end else if (w_int_sum < INT_LO_A) begin
                            r_integ <= INT_W'(INT_LO_A);
                        end else begin
                            r_integ <= INT_W'(w_int_sum);
                        end
                    end
                    r_state <= S_SUM;
                end
                S_SUM: begin
                    r_acc   <= w_acc;
                    r_state <= S_SAT;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Output register: duty word and rail flags update only from the SAT step.
    always_ff @(posedge clk) begin
        if (rst) begin
            duty_out   <= DUTY_W'(OFFSET);
            duty_valid <= 1'b0;
            sat_hi     <= 1'b0;
            sat_lo     <= 1'b0;
        end else if (r_state == S_SAT) begin
            duty_valid <= 1'b1;
            if (r_acc > MAX_A) begin
                duty_out <= DUTY_W'(MAX_DUTY);
                sat_hi   <= 1'b1;
                sat_lo   <= 1'b0;
            end else if (r_acc < MIN_A) begin
                duty_out <= DUTY_W'(MIN_DUTY);
                sat_hi   <= 1'b0;
                sat_lo   <= 1'b1;
            end else begin
                duty_out <= r_acc[DUTY_W-1:0];
                sat_hi   <= 1'b0;
                sat_lo   <= 1'b0;
            end
        end else begin
            duty_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pid_servo_ctrl.sv
// Bench for pid_servo_ctrl: two instances (default and INT_LIM=150) share stimulus.
// A per-sample arithmetic model predicts every output each cycle; directed scenarios pin literal values.
// Random phase toggles en/rst and mixes small and large errors.
module tb_pid_servo_ctrl;

    localparam int SDIV = 4;

    logic        clk = 1'b0;
    logic        rst, en;
    logic [11:0] sp, fb;
    logic [17:0] d0, d1;
    logic        v0, v1, b0, b1, h0, h1, l0, l1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pid_servo_ctrl #(.SAMPLE_DIV(SDIV)) u_dut (
        .clk(clk), .rst(rst), .en(en), .setpoint(sp), .feedback(fb),
        .duty_out(d0), .duty_valid(v0), .busy(b0), .sat_hi(h0), .sat_lo(l0)
    );

    pid_servo_ctrl #(.SAMPLE_DIV(SDIV), .INT_LIM(150)) u_dut_lim (
        .clk(clk), .rst(rst), .en(en), .setpoint(sp), .feedback(fb),
        .duty_out(d1), .duty_valid(v1), .busy(b1), .sat_hi(h1), .sat_lo(l1)
    );

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    longint m_int[2], m_last[2], m_lim[2];
    longint e_duty[2], r_duty[2];
    bit     e_hi[2], e_lo[2], e_valid[2], r_hi[2], r_lo[2];
    bit     e_busy, started;
    int     phase, cnt;

    initial begin
        m_lim[0] = 4096; m_lim[1] = 150;
        started = 1'b0;
    end

    // One sample handled as a single arithmetic step; the result is released 4 clocks after the tick.
    always @(posedge clk) begin
        longint e, d, acc;
        bit tick;
        if (rst) begin
            cnt = 0; phase = 0;
            for (int i = 0; i < 2; i++) begin
                m_int[i] = 0; m_last[i] = 0; e_duty[i] = 75000;
                e_hi[i] = 0; e_lo[i] = 0; e_valid[i] = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) e_valid[i] = 0;
            if (phase == 3) begin
                for (int i = 0; i < 2; i++) begin
                    e_duty[i] = r_duty[i]; e_hi[i] = r_hi[i]; e_lo[i] = r_lo[i]; e_valid[i] = 1;
                end
                phase = 0;
            end else if (phase != 0) begin
                phase++;
            end
            tick = 0;
            if (!en) cnt = 0;
            else if (cnt == SDIV - 1) begin cnt = 0; tick = 1; end
            else cnt++;
            if (tick) begin
                for (int i = 0; i < 2; i++) begin
                    e = longint'(sp) - longint'(fb);
                    d = e - m_last[i];
                    m_last[i] = e;
                    if (!((e_hi[i] && e > 0) || (e_lo[i] && e < 0))) begin
                        m_int[i] = m_int[i] + e;
                        if (m_int[i] > m_lim[i]) m_int[i] = m_lim[i];
                        if (m_int[i] < -m_lim[i]) m_int[i] = -m_lim[i];
                    end
                    acc = 75000 + 100 * e + m_int[i] + 10 * d;
                    if (acc > 100000) begin r_duty[i] = 100000; r_hi[i] = 1; r_lo[i] = 0; end
                    else if (acc < 50000) begin r_duty[i] = 50000; r_hi[i] = 0; r_lo[i] = 1; end
                    else begin r_duty[i] = acc; r_hi[i] = 0; r_lo[i] = 0; end
                end
                phase = 1;
            end
        end
        e_busy  = (phase != 0);
        started = 1'b1;
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (started) begin
            check("duty0",  d0, e_duty[0]);
            check("valid0", v0, e_valid[0]);
            check("busy0",  b0, e_busy);
            check("sathi0", h0, e_hi[0]);
            check("satlo0", l0, e_lo[0]);
            check("duty1",  d1, e_duty[1]);
            check("valid1", v1, e_valid[1]);
            check("busy1",  b1, e_busy);
            check("sathi1", h1, e_hi[1]);
            check("satlo1", l1, e_lo[1]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; en = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_valid(output int waited);
        bit seen;
        seen = 1'b0; waited = 0;
        for (int k = 1; k <= 16; k++) begin
            if (!seen) begin
                @(negedge clk);
                if (v0) begin seen = 1'b1; waited = k; end
            end
        end
        if (!seen) begin
            n_checks++; n_fail++;
            $display("FAIL wait_valid: no duty_valid within 16 cycles, required one");
        end
    endtask

    initial begin
        int w, nv;
        bit seen;
        rst = 1'b1; en = 1'b0; sp = '0; fb = '0;

        // Reset state, and silence while disabled.
        do_reset();
        check("rst_duty", d0, 75000);
        check("rst_busy", b0, 0);
        check("rst_flags", {h0, l0, v0}, 0);
        nv = 0;
        repeat (12) begin @(negedge clk); if (v0 || v1) nv++; end
        check("no_valid_when_disabled", nv, 0);

        // Zero error, with sample timing.
        do_reset();
        sp = 12'd2048; fb = 12'd2048; en = 1'b1;
        wait_valid(w);
        check("zero_first_latency", w, 7);
        check("zero_duty_s1", d0, 75000);
        wait_valid(w);
        check("zero_period", w, 4);
        check("zero_duty_s2", d0, 75000);
        check("zero_flags", {h0, l0}, 0);

        // Step response; the limited instance clamps its integral on sample 2.
        do_reset();
        sp = 12'd100; fb = 12'd0; en = 1'b1;
        wait_valid(w);
        check("step_s1_duty0", d0, 86100);
        check("step_s1_duty1", d1, 86100);
        wait_valid(w);
        check("step_s2_duty0", d0, 85200);
        check("step_s2_duty1", d1, 85150);
        check("step_s2_model_int_lim", m_int[1], 150);

        // High saturation and anti-windup hold.
        do_reset();
        sp = 12'd4095; fb = 12'd0; en = 1'b1;
        wait_valid(w);
        check("hi_s1_duty", d0, 100000);
        check("hi_s1_sathi", h0, 1);
        check("hi_s1_model_int", m_int[0], 4095);
        wait_valid(w);
        check("hi_s2_model_int_held", m_int[0], 4095);
        check("hi_s2_duty", d0, 100000);

        // Low saturation.
        do_reset();
        sp = 12'd0; fb = 12'd4095; en = 1'b1;
        wait_valid(w);
        check("lo_s1_duty", d0, 50000);
        check("lo_s1_satlo", l0, 1);
        check("lo_s1_model_int", m_int[0], -4095);

        // Reset in the middle of a computation.
        do_reset();
        sp = 12'd100; fb = 12'd0; en = 1'b1;
        wait_valid(w);
        check("mid_s1_duty", d0, 86100);
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (!seen) begin @(negedge clk); if (b0) seen = 1'b1; end
        end
        check("mid_saw_busy", seen, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_duty", d0, 75000);
        check("mid_rst_valid", v0, 0);
        @(negedge clk);
        check("mid_no_late_valid", v0, 0);
        wait_valid(w);
        check("mid_after_duty", d0, 86100);

        // Randomised operation with en toggling and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            sp = 12'($urandom_range(0, 4095));
            if ($urandom_range(0, 1) == 0) fb = 12'($urandom_range(0, 4095));
            else fb = 12'(($urandom_range(0, 1) == 0) ? ((sp > 12'd40) ? sp - 12'($urandom_range(0, 40)) : sp)
                                                    : ((sp < 12'd4050) ? sp + 12'($urandom_range(0, 40)) : sp));
            if ($urandom_range(0, 29) == 0) en = ~en;
            rst = ($urandom_range(0, 299) == 0);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
